// File: rtl/inst_loader.sv
// inst_loader: turns a length-prefixed byte stream into little-endian 32-bit instruction-memory writes.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
`timescale 1ns/1ps
module inst_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_CHK} state_t;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
    logic [7:0] r_chk;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            r_state, w_next;
    logic [7:0]        r_n;
    logic [1:0]        r_bidx;
    logic [ADDR_W-1:0] r_widx;
    logic [31:0]       r_asm;
    logic              r_byte_ready, r_mem_we, r_busy, r_done, r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic              w_xfer, w_bad_n, w_last;
    logic [31:0]       w_word;

    assign w_xfer  = byte_valid && r_byte_ready;
    assign w_bad_n = byte_data == 8'd0 || byte_data > 8'(DEPTH);
    assign w_last  = r_widx == ADDR_W'(r_n - 8'd1);
    // Bytes shift in from the top so byte k ends up in bits [8k+7:8k].
    assign w_word  = {byte_data, r_asm[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = start ? S_LEN : r_state;
            S_LEN:          w_next = !w_xfer ? S_LEN : (w_bad_n ? S_DONE : S_DATA);
            S_DATA:         w_next = (w_xfer && r_bidx == 2'd3) ? S_WRITE : S_DATA;
            S_WRITE:        w_next = w_last ? S_TAIL : S_DATA;
            S_CHK:          w_next = w_xfer ? S_DONE : S_CHK;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_n          <= '0;
            r_bidx       <= '0;
            r_widx       <= '0;
            r_asm        <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            r_chk        <= '0;
`endif
        end else begin
            // Handshake and strobe are registered from the next state so they align with it.
            r_byte_ready <= w_next == S_LEN || w_next == S_DATA || w_next == S_CHK;
            r_mem_we     <= w_next == S_WRITE;
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_done       <= 1'b0;
                    r_err        <= 1'b0;
                    r_word_count <= '0;
                    r_busy       <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    r_chk        <= '0;
`endif
                end
                S_LEN: if (w_xfer) begin
                    if (w_bad_n) r_err <= 1'b1;
                    r_n    <= byte_data;
                    r_bidx <= '0;
                    r_widx <= '0;
                end
                S_DATA: if (w_xfer) begin
                    r_asm  <= w_word;
                    r_bidx <= r_bidx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    r_chk  <= r_chk ^ byte_data;
`endif
                    if (r_bidx == 2'd3) begin
                        r_mem_addr  <= r_widx;
                        r_mem_wdata <= w_word;
                    end
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + (ADDR_W+1)'(1);
                    if (!w_last) r_widx <= r_widx + ADDR_W'(1);
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_CHK: if (w_xfer) r_err <= byte_data != r_chk;
`endif
                default: ;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: random and directed loads checked against a queue of expected word writes.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 0, rst_n = 0, start = 0, byte_valid = 0;
    logic [7:0] byte_data = 0;
    logic byte_ready, mem_we, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [ADDR_W:0] word_count;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] img [256];
    logic [ADDR_W+31:0] expq [$];
    logic [ADDR_W-1:0] last_addr = 0;
    logic [31:0] last_wdata = 0;

    inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every cycle: handshake rule, and each write strobe must match the next expected word.
    always @(negedge clk) if (rst_n) begin
        check("ready_rule", byte_ready, busy && !mem_we);
        if (mem_we) begin
            if (expq.size() == 0) check("unexpected_we", mem_we, 0);
            else begin
                logic [ADDR_W+31:0] e;
                e = expq.pop_front();
                check("wr_addr", mem_addr, e[ADDR_W+31:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    task automatic send(input logic [7:0] b, input int gmin, input int gmax);
        int c = 0;
        byte_valid = 1;
        byte_data  = b;
        do begin @(negedge clk); c++; end while (!byte_ready && c < 50);
        if (!byte_ready) check("byte_wait", byte_ready, 1);
        @(posedge clk); #1;
        byte_valid = 0;
        byte_data  = 8'($urandom);
        repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1;
        s = cyc + 1;
        @(posedge clk); #1;
        start = 0;
        check("start_busy", {busy, done, err, word_count}, {1'b1, 2'b00, {(ADDR_W+1){1'b0}}});
    endtask

    task automatic run_load(input int n, input int gmin, input int gmax, input int start_mid,
                            input logic [7:0] cs_flip, input bit use_img);
        int s, c;
        logic [7:0] x, b;
        bit bad, exp_err;
        bad = n == 0 || n > DEPTH;
        exp_err = bad || (CS != 0 && cs_flip != 0);
        x = 0;
        if (!use_img) for (int i = 0; i < 256; i++) img[i] = $urandom;
        if (!bad) for (int i = 0; i < n; i++) expq.push_back({ADDR_W'(i), img[i]});
        pulse_start(s);
        send(8'(n), gmin, gmax);
        if (!bad) begin
            for (int j = 0; j < 4 * n; j++) begin
                b = img[j / 4][8 * (j % 4) +: 8];
                x ^= b;
                start = j == start_mid;
                send(b, gmin, gmax);
                start = 0;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            send(x ^ cs_flip, gmin, gmax);
`endif
        end
        c = 0;
        do begin @(negedge clk); c++; end while (!done && c < 2000);
        check("done", done, 1);
        check("err", err, exp_err);
        check("busy_end", busy, 0);
        check("word_count", word_count, bad ? 0 : n);
        check("writes_left", expq.size(), 0);
        if (gmax == 0) check("latency", cyc - s, bad ? 1 : 1 + 5 * n + CS);
        expq.delete();
    endtask

    initial begin
        int s, c, n;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {byte_ready, mem_we, busy, done, err, mem_addr, mem_wdata, word_count}, 0);
        rst_n = 1;

        img[0] = 32'h401180B3;
        run_load(1, 0, 0, -1, 0, 1);
        check("t1_addr", last_addr, 0);
        check("t1_data", last_wdata, 32'h401180B3);

        img[0] = 32'h00218133; img[1] = 32'h001211B3; img[2] = 32'h00628233;
        run_load(3, 2, 2, -1, 0, 1);
        check("t2_addr", last_addr, 2);
        check("t2_data", last_wdata, 32'h00628233);

        run_load(0, 0, 0, -1, 0, 0);
        run_load(33, 0, 0, -1, 0, 0);
        check("bad_err", err, 1);
        byte_valid = 1;
        repeat (3) @(negedge clk);
        check("done_ready", byte_ready, 0);
        byte_valid = 0;

        run_load(32, 0, 1, 50, 0, 0);
        check("full_last_addr", last_addr, 31);
        check("full_count", word_count, 32);

        for (int i = 0; i < 4; i++) begin img[i] = $urandom; expq.push_back({ADDR_W'(i), img[i]}); end
        pulse_start(s);
        send(8'd4, 0, 0);
        for (int j = 0; j < 10; j++) send(img[j / 4][8 * (j % 4) +: 8], 0, 1);
        c = 0;
        while (expq.size() > 2 && c < 20) begin @(negedge clk); c++; end
        check("abort_writes", expq.size(), 2);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("abort_outputs", {byte_ready, mem_we, busy, done, err, mem_addr, mem_wdata, word_count}, 0);
        expq.delete();
        byte_valid = 1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(posedge clk); #1;
        byte_valid = 0;
        run_load(2, 0, 0, -1, 0, 0);
        check("reload_addr", last_addr, 1);

`ifdef INST_LOADER_CHECKSUM_EN
        img[0] = 32'h11223344;
        run_load(1, 0, 0, -1, 8'h00, 1);
        check("cs_good_err", err, 0);
        run_load(1, 0, 0, -1, 8'h01, 1);
        check("cs_bad_err", err, 1);
        check("cs_bad_data", last_wdata, 32'h11223344);
`endif

        for (int k = 0; k < 10; k++) begin
            n = ($urandom % 4 == 0) ? (($urandom % 2 == 0) ? 0 : int'($urandom_range(255, DEPTH + 1)))
                                    : int'($urandom_range(DEPTH, 1));
            run_load(n, 0, int'($urandom_range(2, 0)), -1, 8'(CS != 0 && $urandom % 3 == 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
